fsm_key_loader: RTL and testbench

//  Key-provisioning end of the locked-FSM key interface: receives an obfuscation key

---
 rtl/fsm_key_loader.sv | 125 ++++++++++++
 tb/tb_fsm_key_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_key_loader.sv
// Serial key loader for a locked FSM: receives key+tag over valid/ready, checks the
// nibble-fold tag, then releases the controller with the key or counts a failed try.
module fsm_key_loader #(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 kin_valid,
  input  logic                 kin_bit,
  input  logic                 kin_last,
  output logic                 kin_ready,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 key_valid,
  output logic                 fsm_hold,
  output logic                 err,
  output logic                 lockout
);

  localparam int unsigned N    = KEY_WIDTH + 4;
  localparam int unsigned BW   = $clog2(N + 1);
  localparam int unsigned NIBS = KEY_WIDTH / 4;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, FAIL, LOCKOUT} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   shreg, shreg_nx;
  logic [BW-1:0]  beat, beat_nx;
  logic [7:0]     idle, idle_nx;
  logic [2:0]     fails, fails_nx;
  logic [3:0]     fold;
  logic           to_fail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      beat  <= '0;
      idle  <= '0;
      fails <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      beat  <= beat_nx;
      idle  <= idle_nx;
      fails <= fails_nx;
    end
  end

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NIBS; i++) fold = fold ^ shreg[i*4 +: 4];
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    beat_nx  = beat;
    idle_nx  = idle;
    fails_nx = fails;
    to_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          shreg_nx = '0;
          beat_nx  = '0;
          idle_nx  = '0;
        end
      end
      LOAD: begin
        if (kin_valid) begin
          for (int unsigned i = 0; i < N; i++)
            if (beat == BW'(i)) shreg_nx[i] = kin_bit;
          beat_nx = beat + BW'(1);
          idle_nx = '0;
          if (beat == BW'(N - 1)) begin
            if (kin_last) state_nx = CHECK;
            else          to_fail  = 1'b1;
          end else if (kin_last) begin
            to_fail = 1'b1;
          end
        end else begin
          idle_nx = idle + 8'd1;
          if (idle_nx == 8'(TIMEOUT)) to_fail = 1'b1;
        end
      end
      CHECK: begin
        if (shreg[N-1:KEY_WIDTH] == fold) state_nx = ARMED;
        else                              to_fail  = 1'b1;
      end
      ARMED: state_nx = ARMED;
      FAIL: begin
        shreg_nx = '0;
        if (fails == 3'(MAX_TRIES)) begin
          state_nx = LOCKOUT;
        end else if (start) begin
          state_nx = LOAD;
          beat_nx  = '0;
          idle_nx  = '0;
        end
      end
      LOCKOUT: state_nx = LOCKOUT;
      default: state_nx = IDLE;
    endcase
    // Every path into FAIL shares the try count and key zeroization here.
    if (to_fail) begin
      state_nx = FAIL;
      shreg_nx = '0;
      fails_nx = (fails == 3'(MAX_TRIES)) ? fails : fails + 3'd1;
    end
  end

  always_comb begin
    kin_ready = (state == LOAD);
    key_valid = (state == ARMED);
    fsm_hold  = (state != ARMED);
    err       = (state == FAIL) || (state == LOCKOUT);
    lockout   = (state == LOCKOUT);
    keyinput  = (state == ARMED) ? shreg[KEY_WIDTH-1:0] : '0;
  end

endmodule

// File: tb/tb_fsm_key_loader.sv
// Self-checking bench for fsm_key_loader: directed and random key loads compared
// against an outcome-level model of the load/authenticate/retry rules.
module tb_fsm_key_loader;

  localparam int KW   = 8;
  localparam int N    = KW + 4;
  localparam int TMO  = 15;
  localparam int MAXT = 3;

  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_ARMED = 3, P_FAIL = 4, P_LOCK = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, kin_valid = 1'b0, kin_bit = 1'b0, kin_last = 1'b0;
  logic          kin_ready, key_valid, fsm_hold, err, lockout;
  logic [KW-1:0] keyinput;

  int vectors = 0;
  int miscompares = 0;

  int            phase = P_IDLE;
  int            m_fails = 0;
  logic [KW-1:0] m_key = '0;

  fsm_key_loader #(.KEY_WIDTH(KW), .TIMEOUT(TMO), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst), .start(start), .kin_valid(kin_valid), .kin_bit(kin_bit),
    .kin_last(kin_last), .kin_ready(kin_ready), .keyinput(keyinput),
    .key_valid(key_valid), .fsm_hold(fsm_hold), .err(err), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] fold(input logic [KW-1:0] k);
    int f = 0;
    for (int j = 0; j < KW / 4; j++) f = f ^ ((int'(k) >> (4 * j)) & 15);
    return 4'(f);
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic expect_outs(input string nm);
    chk({nm, ".kin_ready"}, 32'(kin_ready), 32'(phase == P_LOAD));
    chk({nm, ".key_valid"}, 32'(key_valid), 32'(phase == P_ARMED));
    chk({nm, ".fsm_hold"},  32'(fsm_hold),  32'(phase != P_ARMED));
    chk({nm, ".err"},       32'(err),       32'(phase == P_FAIL || phase == P_LOCK));
    chk({nm, ".lockout"},   32'(lockout),   32'(phase == P_LOCK));
    chk({nm, ".keyinput"},  32'(keyinput),  (phase == P_ARMED) ? 32'(m_key) : 32'd0);
  endtask

  task automatic on_fail(input string nm);
    if (m_fails < MAXT) m_fails++;
    phase = P_FAIL;
    expect_outs({nm, ".fail"});
    if (m_fails == MAXT) begin
      tick();
      phase = P_LOCK;
      expect_outs({nm, ".lock"});
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    rst = 1'b0;
    start = 1'b0; kin_valid = 1'b0; kin_last = 1'b0;
    #1;
    phase = P_IDLE;
    m_fails = 0;
    expect_outs({nm, ".async"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  // last_at == N means kin_last never asserted; stall_at < 0 means only short random gaps.
  task automatic load(input logic [KW-1:0] key, input logic [3:0] tag, input int last_at,
                      input int stall_at, input int stall_len, input bit with_valid,
                      input string nm);
    logic [N-1:0] frame;
    int gap;
    frame = {tag, key};
    if (phase == P_LOCK || phase == P_ARMED) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_outs({nm, ".start_ignored"});
      for (int i = 0; i < N; i++) begin
        kin_valid = 1'b1; kin_bit = frame[i]; kin_last = (i == N - 1);
        tick();
      end
      kin_valid = 1'b0; kin_last = 1'b0;
      tick();
      expect_outs({nm, ".still"});
      return;
    end
    start = 1'b1; kin_valid = with_valid; kin_bit = ~frame[0]; kin_last = 1'b0;
    tick();
    start = 1'b0; kin_valid = 1'b0;
    phase = P_LOAD;
    expect_outs({nm, ".start"});
    for (int i = 0; i < N; i++) begin
      gap = (i == stall_at) ? stall_len : $urandom_range(0, 2);
      if (gap >= TMO) begin
        repeat (TMO) tick();
        on_fail({nm, ".timeout"});
        return;
      end
      repeat (gap) tick();
      kin_valid = 1'b1; kin_bit = frame[i]; kin_last = (i == last_at);
      tick();
      kin_valid = 1'b0; kin_last = 1'b0;
      if ((i == last_at && i < N - 1) || (i == N - 1 && last_at != N - 1)) begin
        on_fail({nm, ".framing"});
        return;
      end
      if (i == N / 2) expect_outs({nm, ".mid"});
    end
    phase = P_CHECK;
    expect_outs({nm, ".check"});
    tick();
    if (tag == fold(key)) begin
      phase = P_ARMED;
      m_key = key;
      expect_outs({nm, ".armed"});
    end else begin
      on_fail({nm, ".tag"});
    end
  endtask

  initial begin
    logic [KW-1:0] k;
    logic [3:0]    tg;
    int kind, last, sat, sl, r;

    repeat (2) @(negedge clk);
    expect_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    load(8'hA5, 4'hF, N - 1, -1, 0, 1'b1, "good_a5");
    load(8'h11, fold(8'h11), N - 1, -1, 0, 1'b0, "armed_ign");
    do_reset("rst_armed");

    load(8'hA5, 4'h3, N - 1, -1, 0, 1'b0, "bad_tag");
    load(8'h69, fold(8'h69), N - 1, -1, 0, 1'b0, "retry_ok");
    do_reset("r1");

    load(8'h5A, fold(8'h5A), 7, -1, 0, 1'b0, "early_last");
    load(8'hC3, fold(8'hC3), N - 1, 4, TMO - 1, 1'b0, "stall14");
    do_reset("r2");

    load(8'h12, fold(8'h12), N, -1, 0, 1'b0, "no_last");
    load(8'h34, fold(8'h34), N - 1, 4, TMO, 1'b0, "tmo_mid");
    load(8'h56, fold(8'h56), N - 1, 0, TMO, 1'b0, "tmo_first");
    load(8'hA5, 4'hF, N - 1, -1, 0, 1'b0, "locked");
    do_reset("r3");

    load(8'h3C, fold(8'h3C), N - 1, -1, 0, 1'b0, "good_3c");
    do_reset("r4");

    for (int it = 0; it < 24; it++) begin
      k = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 4);
      tg = fold(k); last = N - 1; sat = -1; sl = 0;
      case (kind)
        2: tg = fold(k) ^ 4'($urandom_range(1, 15));
        3: last = $urandom_range(0, N - 2);
        4: last = N;
        default: ;
      endcase
      r = $urandom_range(0, 3);
      if (r == 0) begin sat = $urandom_range(0, N - 1); sl = TMO; end
      if (r == 1) begin sat = $urandom_range(0, N - 1); sl = TMO - 1; end
      load(k, tg, last, sat, sl, 1'($urandom_range(0, 1)), "rand");
      if (phase == P_ARMED || phase == P_LOCK) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
